// File: rtl/ycr1_tcm_arb.sv
// TCM grant arbiter: round-robin with starvation override and bounded lock.
// Grant is held from selection through tcm_done, then one idle bubble.
module ycr1_tcm_arb #(
  parameter int NREQ       = 3,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic                    tcm_ack,
  input  logic                    tcm_done,
  output logic [NREQ-1:0]         gnt,
  output logic                    gnt_vld,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    starve_evt
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);
  localparam logic [LW-1:0]   LTOP = LW'(LOCK_MAX - 1);
  localparam logic [NREQ-1:0] ONE  = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NREQ-1:0][SW-1:0] scnt;
  logic [NREQ-1:0][SW-1:0] scnt_inc;
  logic [NREQ-1:0][SW-1:0] scnt_nxt;
  logic [LW-1:0]           lcnt;
  logic [LW-1:0]           lcnt_nxt;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           rr_nxt;
  logic [IW-1:0]           gid_nxt;
  logic [IW-1:0]           rr_win;
  logic [IW-1:0]           st_win;
  logic [NREQ-1:0]         gnt_nxt;
  logic                    sevt_nxt;
  logic                    rr_found;
  logic                    st_found;
  logic                    starve_hit;
  logic                    keep;
  logic                    done_w;
  int                      idx;

  assign gnt_vld = |gnt;
  assign done_w  = (state == WAIT) && tcm_done;

  // Candidate winners for an IDLE selection
  always_comb begin
    st_found = 1'b0;
    st_win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && scnt[i] == SMAX) begin
        st_found = 1'b1;
        st_win   = IW'(i);
      end
    end
    rr_found = 1'b0;
    rr_win   = rr_ptr;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!rr_found && req[IW'(idx)]) begin
        rr_found = 1'b1;
        rr_win   = IW'(idx);
      end
    end
  end

  // Starvation ageing on completions; the lock breaks as soon as a
  // waiting requester reaches the limit on this very completion.
  always_comb begin
    scnt_inc   = scnt;
    starve_hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (done_w && IW'(i) != gnt_id && req[i]
          && scnt[i] != SMAX) begin
        scnt_inc[i] = scnt[i] + 1'b1;
      end
      if (IW'(i) != gnt_id && scnt_inc[i] == SMAX) begin
        starve_hit = 1'b1;
      end
    end
    keep = lock[gnt_id] && req[gnt_id]
        && (lcnt < LTOP) && !starve_hit;
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    gid_nxt   = gnt_id;
    rr_nxt    = rr_ptr;
    lcnt_nxt  = lcnt;
    sevt_nxt  = 1'b0;
    scnt_nxt  = scnt_inc;
    unique case (state)
      IDLE: begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i]) scnt_nxt[i] = '0;
        end
        if (|req) begin
          state_nxt         = GRANT;
          gid_nxt           = st_found ? st_win : rr_win;
          gnt_nxt           = ONE << gid_nxt;
          sevt_nxt          = st_found;
          scnt_nxt[gid_nxt] = '0;
        end
      end
      GRANT: begin
        if (tcm_ack) begin
          state_nxt = WAIT;
        end else if (!req[gnt_id]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          lcnt_nxt  = '0;
        end
      end
      WAIT: begin
        if (tcm_done) begin
          if (keep) begin
            state_nxt = GRANT;
            lcnt_nxt  = lcnt + 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            lcnt_nxt  = '0;
            rr_nxt    = (gnt_id == IW'(NREQ - 1)) ?
                        '0 : gnt_id + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      starve_evt <= 1'b0;
      rr_ptr     <= '0;
      scnt       <= '0;
      lcnt       <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      gnt_id     <= gid_nxt;
      starve_evt <= sevt_nxt;
      rr_ptr     <= rr_nxt;
      scnt       <= scnt_nxt;
      lcnt       <= lcnt_nxt;
    end
  end

endmodule

// File: tb/tb_ycr1_tcm_arb.sv
// Bench for ycr1_tcm_arb: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_ycr1_tcm_arb;

  localparam int N  = 3;
  localparam int SM = 4;
  localparam int LM = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic         tcm_ack = 1'b0;
  logic         tcm_done = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [1:0]   gnt_id;
  logic         starve_evt;

  int checks = 0;
  int errors = 0;

  ycr1_tcm_arb #(.NREQ(N), .STARVE_MAX(SM), .LOCK_MAX(LM)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .tcm_ack    (tcm_ack),
    .tcm_done   (tcm_done),
    .gnt        (gnt),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id),
    .starve_evt (starve_evt)
  );

  always #5 clk = ~clk;

  // Transaction-level model: owner, phase, fairness bookkeeping
  bit m_init = 0;
  int m_phase;
  int m_id;
  int m_rr;
  int m_lock;
  bit m_evt;
  int m_starve [N];
  int m_w;
  bit m_hit;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_phase = 0; m_id = 0; m_rr = 0;
      m_lock = 0; m_evt = 0;
      for (int j = 0; j < N; j++) m_starve[j] = 0;
    end else if (m_init) begin
      m_evt = 0;
      if (m_phase == 0) begin
        for (int j = 0; j < N; j++)
          if (!req[j]) m_starve[j] = 0;
        if (req != 0) begin
          m_w = -1;
          for (int j = 0; j < N; j++)
            if (m_w < 0 && req[j] && m_starve[j] == SM) m_w = j;
          if (m_w >= 0) m_evt = 1;
          else
            for (int k = 0; k < N; k++)
              if (m_w < 0 && req[(m_rr + k) % N]) m_w = (m_rr + k) % N;
          m_id = m_w;
          m_starve[m_w] = 0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (tcm_ack) m_phase = 2;
        else if (!req[m_id]) begin m_phase = 0; m_lock = 0; end
      end else if (tcm_done) begin
        m_hit = 0;
        for (int j = 0; j < N; j++) begin
          if (j != m_id && req[j] && m_starve[j] < SM) m_starve[j]++;
          if (j != m_id && m_starve[j] == SM) m_hit = 1;
        end
        if (lock[m_id] && req[m_id] && m_lock < LM - 1 && !m_hit) begin
          m_lock++; m_phase = 1;
        end else begin
          m_phase = 0; m_lock = 0; m_rr = (m_id + 1) % N;
        end
      end
    end
  end

  logic [N-1:0] exp_gnt;

  always @(negedge clk) begin
    if (m_init) begin
      exp_gnt = (m_phase != 0) ? N'(1 << m_id) : '0;
      checks++;
      if (gnt !== exp_gnt || gnt_vld !== (exp_gnt != 0)
          || gnt_id !== 2'(m_id) || starve_evt !== m_evt
          || !$onehot0(gnt) || gnt_vld !== (|gnt)) begin
        errors++;
        $display("FAIL model t=%0t: gnt=%b vld=%b id=%0d evt=%b required gnt=%b id=%0d evt=%b",
                 $time, gnt, gnt_vld, gnt_id, starve_evt, exp_gnt, m_id, m_evt);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; tcm_ack = 1'b0; tcm_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Wait for a grant, then ack next cycle and done the cycle after
  task automatic xact(output int id, output int waited, output int ev);
    waited = 0;
    while (!gnt_vld && waited < 20) begin tick(); waited++; end
    id = -1; ev = -1;
    if (!gnt_vld) begin
      chk("grant timeout", 0, 1);
      return;
    end
    id = int'(gnt_id);
    ev = int'(starve_evt);
    tcm_ack = 1'b1; tick(); tcm_ack = 1'b0;
    tcm_done = 1'b1; tick(); tcm_done = 1'b0;
  endtask

  int id, w, ev;
  int exp2 [4] = '{0, 1, 2, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("reset gnt", int'(gnt), 0);
    chk("reset vld", int'(gnt_vld), 0);
    chk("reset id", int'(gnt_id), 0);
    chk("reset evt", int'(starve_evt), 0);
    rst = 1'b0;

    // T1: reset while dmem is in WAIT
    req = 3'b010; tick();
    chk("t1 gnt", int'(gnt), 2);
    tcm_ack = 1'b1; tick(); tcm_ack = 1'b0;
    rst = 1'b1; req = 3'b001; tick();
    chk("t1 rst gnt", int'(gnt), 0);
    chk("t1 rst vld", int'(gnt_vld), 0);
    chk("t1 rst id", int'(gnt_id), 0);
    rst = 1'b0; tick();
    chk("t1 regrant", int'(gnt), 1);

    // T2: round robin with one bubble per release
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      xact(id, w, ev);
      chk($sformatf("t2 id%0d", i), id, exp2[i]);
      chk($sformatf("t2 wait%0d", i), w, 1);
    end

    // T3: withdraw before ack leaves rr_ptr alone
    do_reset();
    req = 3'b100; tick();
    chk("t3 gnt", int'(gnt), 4);
    req = 3'b000; tick();
    chk("t3 drop", int'(gnt), 0);
    req = 3'b011; tick();
    chk("t3 rr", int'(gnt), 1);

    // T4: lock bound of eight back-to-back transfers
    do_reset();
    req = 3'b010; lock = 3'b010;
    for (int i = 1; i <= 8; i++) begin
      xact(id, w, ev);
      chk($sformatf("t4 id%0d", i), id, 1);
      chk($sformatf("t4 wait%0d", i), w, (i == 1) ? 1 : 0);
      if (i == 5) req = 3'b011;
    end
    xact(id, w, ev);
    chk("t4 next id", id, 0);
    chk("t4 next wait", w, 1);
    chk("t4 next evt", ev, 0);

    // T5: starvation breaks the lock after four completions
    do_reset();
    req = 3'b010; lock = 3'b010; tick();
    chk("t5 gnt", int'(gnt), 2);
    req = 3'b011;
    tcm_ack = 1'b1; tick(); tcm_ack = 1'b0;
    tcm_done = 1'b1; tick(); tcm_done = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      xact(id, w, ev);
      chk($sformatf("t5 id%0d", i), id, 1);
      chk($sformatf("t5 wait%0d", i), w, 0);
    end
    xact(id, w, ev);
    chk("t5 forced id", id, 0);
    chk("t5 forced wait", w, 1);
    chk("t5 forced evt", ev, 1);

    // T6: stray handshakes
    do_reset();
    tcm_done = 1'b1; tick(); tcm_done = 1'b0;
    chk("t6 done idle", int'(gnt), 0);
    tcm_ack = 1'b1; tick(); tcm_ack = 1'b0;
    chk("t6 ack idle", int'(gnt), 0);
    req = 3'b001; tick();
    tcm_done = 1'b1; tick(); tcm_done = 1'b0;
    chk("t6 done grant", int'(gnt), 1);
    tcm_ack = 1'b1; tick();
    tick(); tcm_ack = 1'b0;
    chk("t6 ack wait", int'(gnt), 1);
    req = 3'b000;
    tcm_ack = 1'b1; tcm_done = 1'b1; tick();
    tcm_ack = 1'b0; tcm_done = 1'b0;
    chk("t6 both", int'(gnt), 0);
    tick();
    chk("t6 stay idle", int'(gnt_vld), 0);

    do_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
